// File: rtl/sky_decode_stage.sv
// Skylark XU decode stage: RV32I field/immediate decode, 32x32 register file,
// load-use hazard detection and the registered bundle for execute.
// Optional feature macro: SKY_DECODE_WB_BYPASS_EN (same-cycle writeback bypass).
module sky_decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  output logic        stall_out,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [31:0] out_imm,
  output logic [2:0]  out_opclass,
  output logic [3:0]  out_alu_op,
  output logic [2:0]  out_funct3,
  output logic        out_rd_we,
  output logic        out_illegal
);

  typedef enum logic [2:0] {
    OC_ALU_R, OC_ALU_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL, OC_JALR, OC_UPPER
  } opclass_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  opclass_t    dec_opclass;
  alu_op_t     dec_alu_op, base_alu_op;
  logic [31:0] dec_imm;
  logic        dec_writes, dec_illegal, uses_rs1, uses_rs2;

  always_comb begin
    case (funct3)
      3'd0:    base_alu_op = ALU_ADD;
      3'd1:    base_alu_op = ALU_SLL;
      3'd2:    base_alu_op = ALU_SLT;
      3'd3:    base_alu_op = ALU_SLTU;
      3'd4:    base_alu_op = ALU_XOR;
      3'd5:    base_alu_op = ALU_SRL;
      3'd6:    base_alu_op = ALU_OR;
      default: base_alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    dec_opclass = OC_ALU_I;
    dec_alu_op  = ALU_ADD;
    dec_imm     = '0;
    dec_writes  = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_opclass = OC_ALU_R;
        dec_writes  = 1'b1;
        uses_rs2    = 1'b1;
        dec_alu_op  = base_alu_op;
        // funct7=0x20 only selects SUB and SRA; anything else is not RV32I
        if (funct7 == 7'b0100000 && funct3 == 3'd0)      dec_alu_op = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'd5) dec_alu_op = ALU_SRA;
        else if (funct7 != 7'b0000000)                   dec_illegal = 1'b1;
      end
      7'b0010011: begin
        dec_opclass = OC_ALU_I;
        dec_writes  = 1'b1;
        dec_imm     = imm_i;
        dec_alu_op  = (funct3 == 3'd5 && in_instr[30]) ? ALU_SRA : base_alu_op;
      end
      7'b0000011: begin
        dec_opclass = OC_LOAD;
        dec_writes  = 1'b1;
        dec_imm     = imm_i;
      end
      7'b0100011: begin
        dec_opclass = OC_STORE;
        dec_imm     = imm_s;
        uses_rs2    = 1'b1;
      end
      7'b1100011: begin
        dec_opclass = OC_BRANCH;
        dec_alu_op  = ALU_SUB;
        dec_imm     = imm_b;
        uses_rs2    = 1'b1;
      end
      7'b1101111: begin
        dec_opclass = OC_JAL;
        dec_writes  = 1'b1;
        dec_imm     = imm_j;
        uses_rs1    = 1'b0;
      end
      7'b1100111: begin
        dec_opclass = OC_JALR;
        dec_writes  = 1'b1;
        dec_imm     = imm_i;
      end
      7'b0110111: begin
        dec_opclass = OC_UPPER;
        dec_alu_op  = ALU_PASSB;
        dec_writes  = 1'b1;
        dec_imm     = imm_u;
        uses_rs1    = 1'b0;
      end
      7'b0010111: begin
        dec_opclass = OC_UPPER;
        dec_writes  = 1'b1;
        dec_imm     = imm_u;
        uses_rs1    = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [31:0] regs [32];
  logic [31:0] rs1_data, rs2_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef SKY_DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == rs1 && rs1 != 5'd0) rs1_data = wb_data;
    if (wb_en && wb_rd == rs2 && rs2 != 5'd0) rs2_data = wb_data;
`endif
  end

  logic load_hit, wb_hit, hazard;

  assign load_hit = ex_is_load && ex_rd != 5'd0 &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
`ifdef SKY_DECODE_WB_BYPASS_EN
  assign wb_hit = 1'b0;
`else
  // Without a bypass the read would see the stale value, so wait one cycle
  assign wb_hit = wb_en && wb_rd != 5'd0 &&
                  ((uses_rs1 && rs1 == wb_rd) || (uses_rs2 && rs2 == wb_rd));
`endif
  assign hazard    = in_valid && (load_hit || wb_hit);
  assign stall_out = reset_n && (stall_in || (hazard && !flush));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush || (!stall_in && (hazard || !in_valid))) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= NOP_INSTR;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_opclass  <= '0;
      out_alu_op   <= '0;
      out_funct3   <= '0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (!stall_in) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_instr    <= in_instr;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= dec_imm;
      out_opclass  <= dec_opclass;
      out_alu_op   <= dec_alu_op;
      out_funct3   <= funct3;
      out_rd_we    <= dec_writes && !dec_illegal && rd != 5'd0;
      out_illegal  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_sky_decode_stage.sv
// Directed bench for sky_decode_stage: table of decode vectors plus
// hand-written sequences for reset, register file, hazards, flush and stall.
module tb_sky_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_pc, in_instr;
  logic        stall_in, flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        stall_out, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_rs1_data, out_rs2_data, out_imm;
  logic [2:0]  out_opclass;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_funct3;
  logic        out_rd_we, out_illegal;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sky_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .stall_in(stall_in), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .stall_out(stall_out), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_opclass(out_opclass), .out_alu_op(out_alu_op), .out_funct3(out_funct3),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        illegal;
    logic [2:0]  opclass;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  initial begin
    vecs[0]  = '{"addi",     32'h0000, 32'h00500093, 0, 3'd1, 4'd0,  32'd5,         5'd1,  1};
    vecs[1]  = '{"add",      32'h0004, 32'h002101B3, 0, 3'd0, 4'd0,  32'd0,         5'd3,  1};
    vecs[2]  = '{"sub",      32'h0008, 32'h402081B3, 0, 3'd0, 4'd1,  32'd0,         5'd3,  1};
    vecs[3]  = '{"sra",      32'h000C, 32'h4020D233, 0, 3'd0, 4'd7,  32'd0,         5'd4,  1};
    vecs[4]  = '{"srai",     32'h0010, 32'h4030D293, 0, 3'd1, 4'd7,  32'h403,       5'd5,  1};
    vecs[5]  = '{"xor",      32'h0014, 32'h0020C4B3, 0, 3'd0, 4'd5,  32'd0,         5'd9,  1};
    vecs[6]  = '{"lui",      32'h0018, 32'h12345337, 0, 3'd7, 4'd10, 32'h12345000,  5'd6,  1};
    vecs[7]  = '{"auipc",    32'h001C, 32'hFFFFF397, 0, 3'd7, 4'd0,  32'hFFFFF000,  5'd7,  1};
    vecs[8]  = '{"lw",       32'h0020, 32'hFF80A403, 0, 3'd2, 4'd0,  32'hFFFFFFF8,  5'd8,  1};
    vecs[9]  = '{"sw",       32'h0024, 32'h0020A623, 0, 3'd3, 4'd0,  32'd12,        5'd12, 0};
    vecs[10] = '{"beq",      32'h0028, 32'hFE208EE3, 0, 3'd4, 4'd1,  32'hFFFFFFFC,  5'd29, 0};
    vecs[11] = '{"jal",      32'h002C, 32'h001000EF, 0, 3'd5, 4'd0,  32'h800,       5'd1,  1};
    vecs[12] = '{"jalr_x0",  32'h0030, 32'h00008067, 0, 3'd6, 4'd0,  32'd0,         5'd0,  0};
    vecs[13] = '{"ill_ones", 32'h0034, 32'hFFFFFFFF, 1, 3'd0, 4'd0,  32'd0,         5'd0,  0};

    reset_n = 1'b0;
    drive(1'b0, '0, 32'h13);
    stall_in = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    ex_is_load = 1'b0; ex_rd = '0;
    #12;
    check("reset_stall_out", {31'd0, stall_out}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_instr", out_instr, 32'h13);
    check("reset_imm", out_imm, 32'd0);
    stall_in = 1'b0;
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].instr);
      step();
      check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({vecs[i].name, "_illegal"}, {31'd0, out_illegal}, {31'd0, vecs[i].illegal});
      check({vecs[i].name, "_rd_we"}, {31'd0, out_rd_we}, {31'd0, vecs[i].rd_we});
      if (!vecs[i].illegal) begin
        check({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
        check({vecs[i].name, "_instr"}, out_instr, vecs[i].instr);
        check({vecs[i].name, "_opclass"}, {29'd0, out_opclass}, {29'd0, vecs[i].opclass});
        check({vecs[i].name, "_alu_op"}, {28'd0, out_alu_op}, {28'd0, vecs[i].alu_op});
        check({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
        check({vecs[i].name, "_rd"}, {27'd0, out_rd}, {27'd0, vecs[i].rd});
      end
    end

    // mul encoding: funct7 = 1 on OP is not RV32I
    drive(1'b1, 32'h40, 32'h02208133);
    step();
    check("ill_funct7", {30'd0, out_illegal, out_rd_we}, 32'b10);

    // register write then read x2 on both ports; x0 write must be dropped
    drive(1'b0, '0, 32'h13);
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
    step();
    wb_rd = 5'd0; wb_data = 32'h5555_5555;
    step();
    wb_en = 1'b0;
    check("bubble_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h50, 32'h002101B3);
    step();
    check("rd_rs1_data", out_rs1_data, 32'hDEAD_BEEF);
    check("rd_rs2_data", out_rs2_data, 32'hDEAD_BEEF);
    check("rd_alu_op", {28'd0, out_alu_op}, 32'd0);
    drive(1'b1, 32'h54, 32'h000001B3);
    step();
    check("x0_rs1_data", out_rs1_data, 32'd0);

    // load-use: one bubble then the add issues
    ex_is_load = 1'b1; ex_rd = 5'd5;
    drive(1'b1, 32'h58, 32'h00028333);
    #1;
    check("lu_stall", {31'd0, stall_out}, 32'd1);
    step();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    ex_is_load = 1'b0;
    #1;
    check("lu_stall_clear", {31'd0, stall_out}, 32'd0);
    step();
    check("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    check("lu_issue_instr", out_instr, 32'h00028333);

    // flush alongside a hazard: no stall, bubble out
    ex_is_load = 1'b1; ex_rd = 5'd5; flush = 1'b1;
    #1;
    check("fl_hz_stall", {31'd0, stall_out}, 32'd0);
    step();
    flush = 1'b0; ex_is_load = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_instr", out_instr, 32'h13);

    // hold for three cycles while the input changes
    drive(1'b1, 32'h60, 32'h00500093);
    step();
    stall_in = 1'b1;
    drive(1'b1, 32'h64, 32'h12345337);
    for (int c = 0; c < 3; c++) begin
      step();
      check("hold_stall", {31'd0, stall_out}, 32'd1);
      check("hold_instr", out_instr, 32'h00500093);
      check("hold_pc", out_pc, 32'h60);
      check("hold_imm", out_imm, 32'd5);
    end

    // flush beats stall_in
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_st_valid", {31'd0, out_valid}, 32'd0);
    check("fl_st_instr", out_instr, 32'h13);

    // asynchronous reset mid-stall, then the register file must be clear
    drive(1'b1, 32'h70, 32'h00500093);
    stall_in = 1'b0;
    step();
    stall_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_stall", {31'd0, stall_out}, 32'd0);
    stall_in = 1'b0;
    step();
    reset_n = 1'b1;
    drive(1'b1, 32'h80, 32'h002101B3);
    step();
    check("rf_cleared", out_rs1_data, 32'd0);

    // same-cycle writeback of x7 while reading it
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'd9;
    drive(1'b1, 32'h90, 32'h00038413);
`ifdef SKY_DECODE_WB_BYPASS_EN
    #1;
    check("wb_stall", {31'd0, stall_out}, 32'd0);
    step();
    wb_en = 1'b0;
    check("wb_valid", {31'd0, out_valid}, 32'd1);
    check("wb_rs1_data", out_rs1_data, 32'd9);
`else
    #1;
    check("wb_stall", {31'd0, stall_out}, 32'd1);
    step();
    wb_en = 1'b0;
    check("wb_bubble", {31'd0, out_valid}, 32'd0);
    step();
    check("wb_valid", {31'd0, out_valid}, 32'd1);
    check("wb_rs1_data", out_rs1_data, 32'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/sky_decode_stage.md
# sky_decode_stage

Second stage of the skylark XU integer pipeline, directly downstream of fetch. Takes the fetched PC/instruction pair, decodes RV32I fields and immediates, reads the 32x32 integer register file (write port driven by writeback), detects load-use hazards, and registers a decoded bundle for execute. It is the source of the `stall` seen by fetch and the kill point for branch flushes.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`. Encoding decoded into bubbles; reported in `out_instr` for killed slots.
- `clk` in 1 — pipeline clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — fetch slot holds a real instruction.
- `in_pc` in 32 — PC of `in_instr`.
- `in_instr` in 32 — instruction word.
- `stall_in` in 1 — downstream cannot accept; hold outputs.
- `flush` in 1 — branch taken in execute; kill the current input and the output slot.
- `wb_en` in 1, `wb_rd` in 5, `wb_data` in 32 — register file write port.
- `ex_is_load` in 1, `ex_rd` in 5 — the instruction currently in execute is a load targeting `ex_rd`.
- `stall_out` out 1 — to fetch `stall`; combinational.
- `out_valid` out 1 — decoded bundle valid.
- `out_pc` out 32, `out_instr` out 32.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each.
- `out_rs1_data`, `out_rs2_data` out 32 each.
- `out_imm` out 32 — sign-extended immediate.
- `out_opclass` out 3 — 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 UPPER.
- `out_alu_op` out 4 — 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `out_funct3` out 3 — raw funct3, used for load/store width and branch condition.
- `out_rd_we` out 1 — the instruction writes `rd`, and `rd` is not 0.
- `out_illegal` out 1 — unknown opcode, or an invalid funct7 on OP.

## Operation
- **Decode:** standard RV32I immediate formats I/S/B/U/J, all sign-extended.
  - LUI: UPPER with PASSB. AUIPC: UPPER with ADD, where execute adds the PC.
  - SUB/SRA: selected by `funct7[5]`. SRAI is decoded from `imm[10]`.
- **Illegal instruction:** `out_valid`=1, `out_illegal`=1, `out_rd_we`=0, other fields don't-care.
- **Register file:**
  - Synchronous write on the `clk` edge when `wb_en` and `wb_rd`≠0.
  - Combinational read. x0 always reads 0.
  - All entries are cleared on reset.
- **Source usage:**
  - Uses rs1: everything except LUI, AUIPC and JAL.
  - Uses rs2: ALU_R, STORE and BRANCH.
- **Hazard:** `hazard` = `in_valid` & `ex_is_load` & `ex_rd`≠0 & (uses rs1 & rs1==`ex_rd` | uses rs2 & rs2==`ex_rd`).
- **`stall_out`** = `stall_in` | (`hazard` & !`flush`).
- **Per-edge priority:**
  1. `flush`: the output slot becomes a bubble.
  2. `stall_in`: all outputs hold.
  3. `hazard`: the output slot becomes a bubble and fetch holds.
  4. Otherwise: latch the decoded `in_*`. If `in_valid`=0, latch a bubble.
- **Bubble:** `out_valid`=0, `out_instr`=`NOP_INSTR`, `out_rd_we`=0, `out_illegal`=0.
- **Writeback during stalls:** register file writes occur regardless of stall or flush.

## Timing
- Decode latency is 1 cycle, from `in_*` to `out_*`.
- All `out_*` outputs are registered. `stall_out` is combinational from the inputs.
- Reset values:
  - All `out_*` are 0, except `out_instr`=`NOP_INSTR`.
  - `stall_out`=0 while `reset_n` is low.
  - The register file is all-zero.
- Reset asserted mid-stall clears everything immediately, asynchronously.
- A load-use dependency costs exactly one bubble. On the next cycle, `ex_is_load` refers to the bubble, so the hazard clears.
- `flush` together with `hazard`: no stall. The instruction is killed and fetch redirects.
- `flush` together with `stall_in`: flush wins, and the output becomes a bubble.

## Configuration
- `SKY_DECODE_WB_BYPASS_EN` defined:
  - Register reads return `wb_data` when `wb_en` and `wb_rd`==rs and rs≠0 in the same cycle.
  - No writeback-related stall.
- `SKY_DECODE_WB_BYPASS_EN` undefined:
  - Reads return the pre-write value.
  - The hazard term additionally includes `wb_en` & `wb_rd`≠0 & a used source equal to `wb_rd`. This costs a one-cycle bubble, after which the written value is read.

## Test plan
- **Decode:** reset, then `in_instr`=`32'h00500093` (addi x1,x0,5) at pc 0 → next cycle:
  - `out_valid`=1, `out_opclass`=1, `out_alu_op`=0, `out_imm`=5, `out_rd`=1, `out_rd_we`=1.
- **Register read:** write x2=`32'hDEAD_BEEF` via `wb_*`, then issue add x3,x2,x2 → `out_rs1_data`=`out_rs2_data`=`32'hDEADBEEF`, `out_alu_op`=0.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, input add x6,x5,x0 → `stall_out`=1 for one cycle and a bubble is emitted. Next cycle the add is issued with `out_valid`=1.
- **Flush and hold:**
  - `flush`=1 with valid input → next `out_valid`=0, `out_instr`=`32'h13`.
  - `stall_in`=1 for 3 cycles → outputs are unchanged and `stall_out`=1.
- **Corner decodes:**
  - `in_instr`=`32'hFFFF_FFFF` → `out_illegal`=1, `out_rd_we`=0.
  - beq with imm −4 → `out_imm`=`32'hFFFF_FFFC`.
  - Any write to x0 → x0 still reads 0.
- **Same-cycle writeback:** `wb_en`, `wb_rd`=7, `wb_data`=9 in the same cycle as a read of x7:
  - Macro defined: `out_rs1_data`=9 with no stall.
  - Macro undefined: one bubble, then `out_rs1_data`=9.
